// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and helpers for the 1-to-N stream demultiplexer.
//   sel_width(n)  : width of a channel index for n channels (at least 1 bit)
//   DROP_CNT_W    : width of the saturating drop counter
//   DROP_CNT_MAX  : value at which the drop counter saturates
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  // A single-channel demux would give $clog2(1) = 0; keep the index at
  // least one bit wide so the select port is always a legal vector.
  function automatic int sel_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry output register for a single demux channel.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset (clears full flag and data)
//   load_i        write data_i into the slot this cycle (caller guarantees
//                 can_accept_o is high whenever load_i is asserted)
//   data_i        W-bit word to store
//   ready_i       downstream consumer ready for this channel
//   full_o        slot holds a word (drives the channel's valid)
//   data_o        stored word (drives the channel's data)
//   can_accept_o  slot can take a word this cycle: empty, or full and being
//                 drained in the same cycle
// -----------------------------------------------------------------------------
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         full_o,
  output logic [W-1:0] data_o,
  output logic         can_accept_o
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Pass-through drain: a full slot whose consumer is ready frees up at the
  // same edge, so it may be reloaded without a bubble.
  assign can_accept_o = !full_q || ready_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      // Load wins over drain: the slot stays full holding the new word.
      full_d = 1'b1;
      data_d = data_i;
    end else if (ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/demux1ton_stream.sv
// -----------------------------------------------------------------------------
// demux1ton_stream
// Registered, flow-controlled 1-to-N stream demultiplexer. Each accepted input
// word is steered into a one-entry register on the selected output channel.
//
// Handshake (all streams): a word transfers on a rising clock edge where
// valid && ready are both high. ready never depends on valid on the same
// interface. A producer holds valid and its payload until the transfer.
//
// Parameters:
//   N      number of output channels (2..16)
//   W      data width (1..64)
//   SEL_W  select width, derived from N; not meant to be overridden
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   s_valid   input word valid
//   s_ready   input word accepted when s_valid && s_ready
//   s_data    input word
//   s_sel     destination channel index
//   s_bcast   broadcast request (only with DEMUX_BCAST_EN defined)
//   m_valid   per-channel output valid
//   m_ready   per-channel consumer ready
//   m_data    channel k occupies bits [k*W +: W]
//   drop_cnt  saturating count of words dropped for out-of-range select
//
// Build option: DEMUX_BCAST_EN adds s_bcast; a broadcast word loads every
// slot at once and needs all slots able to accept.
// -----------------------------------------------------------------------------
module demux1ton_stream
  import demux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = sel_width(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [W-1:0]          s_data,
  input  logic [SEL_W-1:0]      s_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                  s_bcast,
`endif
  output logic [N-1:0]          m_valid,
  input  logic [N-1:0]          m_ready,
  output logic [N*W-1:0]        m_data,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [N-1:0]          slot_acc;
  logic [N-1:0]          slot_load;
  logic [N-1:0]          sel_onehot;
  logic                  sel_in_range;
  logic                  sel_acc;
  logic                  bcast;
  logic                  handshake;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;

`ifdef DEMUX_BCAST_EN
  assign bcast = s_bcast;
`else
  assign bcast = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Select decode. When N is not a power of two some select codes name no
  // channel; those decode to an all-zero one-hot and are treated as drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (s_sel == SEL_W'(k)) begin
        sel_onehot[k] = 1'b1;
      end
    end
  end

  assign sel_in_range = |sel_onehot;

  // Accept of the addressed slot, or 0 when the select is out of range.
  assign sel_acc = |(sel_onehot & slot_acc);

  // ---------------------------------------------------------------------------
  // s_ready mux. Out-of-range words are always taken (and discarded) so a bad
  // select can never wedge the input stream.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready = 1'b1;
    if (bcast) begin
      s_ready = &slot_acc;
    end else if (sel_in_range) begin
      s_ready = sel_acc;
    end
  end

  // No transfer completes while reset is asserted.
  assign handshake = s_valid && s_ready && !rst;

  always_comb begin
    slot_load = '0;
    if (handshake) begin
      slot_load = bcast ? {N{1'b1}} : sel_onehot;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: saturates, and broadcasts never count as drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (handshake && !bcast && !sel_in_range && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

  // ---------------------------------------------------------------------------
  // Per-channel one-entry slots.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(
      .W (W)
    ) u_slot (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_i       (slot_load[k]),
      .data_i       (s_data),
      .ready_i      (m_ready[k]),
      .full_o       (m_valid[k]),
      .data_o       (m_data[k*W +: W]),
      .can_accept_o (slot_acc[k])
    );
  end

endmodule
